// File: rtl/imm_encode_unit_if.sv
// Request/response bundle for the immediate encoder.
// Master drives requests and the output ready; slave is the encoder.
interface imm_encode_unit_if;
    logic        InValid;
    logic        InReady;
    logic [31:0] Imm;
    logic [2:0]  Type;
    logic [6:0]  Opcode;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Instr;
    logic        RangeErr;
    logic [7:0]  ErrCount;

    modport master (
        output InValid, Imm, Type, Opcode, OutReady,
        input  InReady, OutValid, Instr, RangeErr, ErrCount
    );

    modport slave (
        input  InValid, Imm, Type, Opcode, OutReady,
        output InReady, OutValid, Instr, RangeErr, ErrCount
    );
endinterface

// File: rtl/imm_encode_unit.sv
// Two-stage immediate encoder: S1 captures the request and its range
// flag, S2 holds the packed instruction word until the consumer takes it.
module imm_encode_unit #(
    parameter int CHECK_RANGE = 1
) (
    input logic              clk,
    input logic              rst,
    imm_encode_unit_if.slave bus
);
    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;

    localparam bit CHK = (CHECK_RANGE != 0);

    logic        s1v_q, s1v_d;
    logic [31:0] s1_imm_q, s1_imm_d;
    logic [2:0]  s1_type_q, s1_type_d;
    logic [6:0]  s1_op_q, s1_op_d;
    logic        s1_err_q, s1_err_d;
    logic        s2v_q, s2v_d;
    logic [31:0] s2_instr_q, s2_instr_d;
    logic        s2_err_q, s2_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        s2_adv;
    logic        in_rdy;
    logic        in_fire;
    logic        out_fire;
    logic        rng_err;
    logic [31:7] imm_f;
    logic [31:0] packed_w;

    assign s2_adv   = !s2v_q || bus.OutReady;
    assign in_rdy   = !rst && (!s1v_q || s2_adv);
    assign in_fire  = bus.InValid && in_rdy;
    assign out_fire = s2v_q && bus.OutReady;

    assign bus.InReady  = in_rdy;
    assign bus.OutValid = s2v_q;
    assign bus.Instr    = s2_instr_q;
    assign bus.RangeErr = s2_err_q;
    assign bus.ErrCount = err_cnt_q;

    // Range check on the incoming immediate: does it fit the type's field?
    always_comb begin
        rng_err = 1'b1;
        unique case (bus.Type)
            T_I, T_S: rng_err = !(&bus.Imm[31:11] || ~|bus.Imm[31:11]);
            T_B: rng_err = !(&bus.Imm[31:12] || ~|bus.Imm[31:12])
                           || bus.Imm[0];
            T_J: rng_err = !(&bus.Imm[31:20] || ~|bus.Imm[31:20])
                           || bus.Imm[0];
            T_U: rng_err = |bus.Imm[11:0];
            T_R: rng_err = |bus.Imm;
            default: rng_err = 1'b1;
        endcase
    end

    // Scatter the captured immediate into the instruction field layout.
    always_comb begin
        imm_f = '0;
        unique case (s1_type_q)
            T_I: imm_f[31:20] = s1_imm_q[11:0];
            T_S: begin
                imm_f[31:25] = s1_imm_q[11:5];
                imm_f[11:7]  = s1_imm_q[4:0];
            end
            T_B: begin
                imm_f[31]    = s1_imm_q[12];
                imm_f[30:25] = s1_imm_q[10:5];
                imm_f[11:8]  = s1_imm_q[4:1];
                imm_f[7]     = s1_imm_q[11];
            end
            T_U: imm_f[31:12] = s1_imm_q[31:12];
            T_J: begin
                imm_f[31]    = s1_imm_q[20];
                imm_f[30:21] = s1_imm_q[10:1];
                imm_f[20]    = s1_imm_q[11];
                imm_f[19:12] = s1_imm_q[19:12];
            end
            default: imm_f = '0;
        endcase
        packed_w = {imm_f, s1_op_q};
    end

    // Next-state: S1 refills while S2 drains, S2 holds under backpressure.
    always_comb begin
        s1v_d      = s1v_q;
        s1_imm_d   = s1_imm_q;
        s1_type_d  = s1_type_q;
        s1_op_d    = s1_op_q;
        s1_err_d   = s1_err_q;
        s2v_d      = s2v_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (s2_adv) begin
            s2v_d      = s1v_q;
            s2_instr_d = s1v_q ? packed_w : '0;
            s2_err_d   = s1v_q && s1_err_q;
        end

        if (in_fire) begin
            s1v_d     = 1'b1;
            s1_imm_d  = bus.Imm;
            s1_type_d = bus.Type;
            s1_op_d   = bus.Opcode;
            s1_err_d  = CHK && rng_err;
        end else if (s2_adv) begin
            s1v_d = 1'b0;
        end

        if (out_fire && s2_err_q && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Pipeline and error counter registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1v_q      <= 1'b0;
            s1_imm_q   <= '0;
            s1_type_q  <= '0;
            s1_op_q    <= '0;
            s1_err_q   <= 1'b0;
            s2v_q      <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1v_q      <= s1v_d;
            s1_imm_q   <= s1_imm_d;
            s1_type_q  <= s1_type_d;
            s1_op_q    <= s1_op_d;
            s1_err_q   <= s1_err_d;
            s2v_q      <= s2v_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_imm_encode_unit.sv
// Scoreboard bench for imm_encode_unit: arithmetic reference model,
// randomized requests, backpressure, reset and counter saturation.
module tb_imm_encode_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    imm_encode_unit_if bus ();

    imm_encode_unit #(.CHECK_RANGE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        int          typ;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   model_cnt = 0;
    int   rdy_mode  = 0;
    bit   bp_done   = 0;

    logic        hold_v = 1'b0;
    logic [31:0] hold_instr;
    logic        hold_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Representability by signed value range and alignment.
    function automatic logic model_err(input logic [31:0] imm, input int typ);
        int s;
        s = imm;
        case (typ)
            0: return imm != 0;
            1, 2: return !(s >= -2048 && s <= 2047);
            3: return !(s >= -4096 && s <= 4095 && (imm % 2) == 0);
            4: return (imm % 4096) != 0;
            5: return !(s >= -1048576 && s <= 1048575 && (imm % 2) == 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_enc(input logic [31:0] imm,
                                              input int typ,
                                              input logic [6:0] op);
        logic [31:0] r;
        r = 0;
        case (typ)
            1: r = (imm & 32'hFFF) << 20;
            2: r = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            3: r = (((imm >> 12) & 32'h1) << 31)
                 | (((imm >> 5) & 32'h3F) << 25)
                 | (((imm >> 1) & 32'hF) << 8)
                 | (((imm >> 11) & 32'h1) << 7);
            4: r = imm & 32'hFFFFF000;
            5: r = (((imm >> 20) & 32'h1) << 31)
                 | (((imm >> 1) & 32'h3FF) << 21)
                 | (((imm >> 11) & 32'h1) << 20)
                 | (((imm >> 12) & 32'hFF) << 12);
            default: r = 0;
        endcase
        return r | {25'd0, op};
    endfunction

    // Standard sign-extending decode of the immediate from an instruction.
    function automatic logic [31:0] decode(input logic [31:0] instr,
                                           input int typ);
        int v;
        int hi;
        v = instr;
        case (typ)
            1: begin
                hi = v >>> 20;
                return hi;
            end
            2: begin
                hi = v >>> 25;
                return (hi << 5) | ((instr >> 7) & 32'h1F);
            end
            3: begin
                hi = v >>> 31;
                return (hi << 12) | (((instr >> 7) & 32'h1) << 11)
                     | (((instr >> 25) & 32'h3F) << 5)
                     | (((instr >> 8) & 32'hF) << 1);
            end
            4: return instr & 32'hFFFFF000;
            5: begin
                hi = v >>> 31;
                return (hi << 20) | (((instr >> 12) & 32'hFF) << 12)
                     | (((instr >> 20) & 32'h1) << 11)
                     | (((instr >> 21) & 32'h3FF) << 1);
            end
            default: return 0;
        endcase
    endfunction

    task automatic send(input logic [31:0] imm, input int typ,
                        input logic [6:0] op);
        exp_t e;
        bus.InValid = 1'b1;
        bus.Imm     = imm;
        bus.Type    = typ[2:0];
        bus.Opcode  = op;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.InReady) begin
                e.imm   = imm;
                e.typ   = typ;
                e.instr = model_enc(imm, typ, op);
                e.err   = model_err(imm, typ);
                sb.push_back(e);
                @(posedge clk);
                #1;
                bus.InValid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got no InReady expected accept");
        bus.InValid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !bus.OutValid) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.OutReady = 1'b1;
            1: bus.OutReady = 1'($urandom % 2);
            default: bus.OutReady = 1'b0;
        endcase
    end

    // Monitor: pops and compares on every output transfer.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_inready", {31'd0, bus.InReady}, 0);
            chk("rst_outvalid", {31'd0, bus.OutValid}, 0);
            chk("rst_errcount", {24'd0, bus.ErrCount}, 0);
            sb.delete();
            model_cnt = 0;
            hold_v    = 1'b0;
        end else begin
            chk("errcount", {24'd0, bus.ErrCount}, model_cnt);
            if (hold_v) begin
                chk("hold_valid", {31'd0, bus.OutValid}, 1);
                chk("hold_instr", bus.Instr, hold_instr);
                chk("hold_err", {31'd0, bus.RangeErr}, {31'd0, hold_err});
            end
            hold_v     = bus.OutValid && !bus.OutReady;
            hold_instr = bus.Instr;
            hold_err   = bus.RangeErr;
            if (bus.OutValid && bus.OutReady) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%08h expected none",
                             bus.Instr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("instr", bus.Instr, e.instr);
                    chk("range_err", {31'd0, bus.RangeErr}, {31'd0, e.err});
                    if (!e.err && e.typ <= 5) begin
                        chk("round_trip", decode(bus.Instr, e.typ), e.imm);
                    end
                    if (e.err && model_cnt < 255) model_cnt++;
                end
            end
        end
    end

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 5)
            0: return r;
            1: return {{20{r[11]}}, r[11:0]};
            2: return {{19{r[12]}}, r[12:1], 1'b0};
            3: return {{11{r[20]}}, r[20:1], 1'b0};
            default: return {r[31:12], 12'd0};
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.InValid  = 1'b0;
        bus.Imm      = '0;
        bus.Type     = '0;
        bus.Opcode   = '0;
        bus.OutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_instr", bus.Instr, 0);
        chk("reset_range_err", {31'd0, bus.RangeErr}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, bus.InReady}, 1);
        @(posedge clk);
        #1;

        send(32'hFFFFF800, 1, 7'h13);
        @(posedge clk);
        #1;
        chk("i_latency_valid", {31'd0, bus.OutValid}, 1);
        chk("i_instr", bus.Instr, 32'h80000013);
        chk("i_err", {31'd0, bus.RangeErr}, 0);

        send(32'h00000FFE, 3, 7'h63);
        send(32'h00001000, 3, 7'h63);
        drain();
        chk("b_errcount", {24'd0, bus.ErrCount}, 1);
        send(32'h000FFFFE, 5, 7'h6F);
        send(32'h12345001, 4, 7'h37);
        drain();
        chk("ju_errcount", {24'd0, bus.ErrCount}, 2);

        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(32'h00000123, 1, 7'h13);
        send(32'hFFFFFFF0, 2, 7'h23);
        chk("bp_inready_low", {31'd0, bus.InReady}, 0);
        bp_done = 0;
        fork
            begin
                send(32'h00000040, 3, 7'h63);
                send(32'hABCDE000, 4, 7'h37);
                bp_done = 1;
            end
        join_none
        repeat (5) @(posedge clk);
        #1;
        chk("bp_blocked_valid", {31'd0, bus.OutValid}, 1);
        chk("bp_blocked_ready", {31'd0, bus.InReady}, 0);
        rdy_mode = 0;
        for (int i = 0; i < 100 && !bp_done; i++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_all_accepted", {31'd0, bp_done}, 1);
        drain();

        rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            send(rand_imm(), int'($urandom % 8), 7'($urandom));
            if ($urandom % 4 == 0) begin
                repeat ($urandom % 3) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();

        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(32'h00000001, 7, 7'h33);
        send(32'h00000002, 6, 7'h33);
        rst = 1'b1;
        #1;
        chk("mid_rst_outvalid", {31'd0, bus.OutValid}, 0);
        chk("mid_rst_errcount", {24'd0, bus.ErrCount}, 0);
        chk("mid_rst_inready", {31'd0, bus.InReady}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        chk("ready_after_release", {31'd0, bus.InReady}, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale_out", {31'd0, bus.OutValid}, 0);
        end

        for (int n = 0; n < 300; n++) begin
            send($urandom, 7, 7'h0B);
        end
        drain();
        chk("errcount_sat", {24'd0, bus.ErrCount}, 255);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
